// File: rtl/mips_mc_control_hs.sv
// mips_mc_control_hs: multicycle MIPS control FSM driving the shared datapath muxes/enables,
// with a request/ready memory handshake and timeout into a sticky ERROR state.
// Latency: outputs decode the current state; FETCH write enables and the MEM_WR retire
// also follow mem_ready in the same cycle. Memory stalls are unbounded unless MEM_TIMEOUT > 0.
// Backpressure: mem_req is held until mem_ready; mem_ready is ignored while mem_req is low.
// Optional: define MIPS_CTRL_PERF_CNT_EN to add the cycle/instr/stall performance counters.
module mips_mc_control_hs #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 5,
   parameter int STATE_W     = 5
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         op_code,
   input  logic [5:0]         funct,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               PCWrite,
   output logic               PCWriteCond,
   output logic               IorD,
   output logic               MemWrite,
   output logic               IRWrite,
   output logic               ALUSrcA,
   output logic               RegWrite,
   output logic               EQorNE,
   output logic               Error,
   output logic [1:0]         ALUSrcB,
   output logic [1:0]         PCSource,
   output logic [1:0]         RegDst,
   output logic [1:0]         MemtoReg,
   output logic [2:0]         ALUOp,
   output logic               retire,
   output logic [STATE_W-1:0] state
`ifdef MIPS_CTRL_PERF_CNT_EN
   ,
   output logic [31:0]        cycle_cnt,
   output logic [31:0]        instr_cnt,
   output logic [31:0]        stall_cnt
`endif
);

   // Opcode / funct codes (MIPS-I encodings, shared with the datapath defines)
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   // ALU operation codes understood by the ALU control block
   localparam logic [2:0] ALU_AND  = 3'b000;
   localparam logic [2:0] ALU_OR   = 3'b001;
   localparam logic [2:0] ALU_ADD  = 3'b010;
   localparam logic [2:0] ALU_XOR  = 3'b011;
   localparam logic [2:0] ALU_RT   = 3'b100;  // decode from funct
   localparam logic [2:0] ALU_SUB  = 3'b110;
   localparam logic [2:0] ALU_SLT  = 3'b111;

   // Timeout fires on the cycle the counter would step onto MEM_TIMEOUT
   localparam bit             TO_EN   = (MEM_TIMEOUT > 0);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   typedef enum logic [4:0] {
      FETCH    = 5'd0,
      DECODE   = 5'd1,
      EXEC_R   = 5'd2,
      WB_R     = 5'd3,
      EXEC_I   = 5'd4,
      WB_I     = 5'd5,
      MEM_ADDR = 5'd6,
      MEM_RD   = 5'd7,
      MEM_WB   = 5'd8,
      MEM_WR   = 5'd9,
      EXEC_J   = 5'd10,
      EXEC_JR  = 5'd11,
      EXEC_JAL = 5'd12,
      BRANCH   = 5'd13,
      ERROR    = 5'd14
   } state_t;

   state_t          state_q, state_d;
   logic [TO_W-1:0] to_q, to_d;
   logic            stall;
   logic            timeout_hit;

   assign state       = STATE_W'(state_q);
   assign stall       = mem_req && !mem_ready;
   assign timeout_hit = TO_EN && stall && (to_q == TO_LAST);

   // Datapath controls decoded from the current state; reset forces every enable low
   // in the same cycle so an in-flight access is dropped without a write.
   always_comb begin
      mem_req     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      ALUSrcA     = 1'b0;
      RegWrite    = 1'b0;
      EQorNE      = 1'b1;
      Error       = 1'b0;
      ALUSrcB     = 2'b01;
      PCSource    = 2'b00;
      RegDst      = 2'b00;
      MemtoReg    = 2'b00;
      ALUOp       = ALU_ADD;
      retire      = 1'b0;
      if (!rst) begin
         case (state_q)
            FETCH: begin
               mem_req = 1'b1;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            DECODE: begin
               ALUSrcB = 2'b11;
            end
            EXEC_R: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b00;
               ALUOp   = ALU_RT;
            end
            WB_R: begin
               RegWrite = 1'b1;
               RegDst   = 2'b01;
               retire   = 1'b1;
            end
            EXEC_I: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
               case (op_code)
                  OP_ANDI: ALUOp = ALU_AND;
                  OP_ORI:  ALUOp = ALU_OR;
                  OP_XORI: ALUOp = ALU_XOR;
                  OP_SLTI: ALUOp = ALU_SLT;
                  default: ALUOp = ALU_ADD;
               endcase
            end
            WB_I: begin
               RegWrite = 1'b1;
               retire   = 1'b1;
            end
            MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            MEM_RD: begin
               mem_req = 1'b1;
               IorD    = 1'b1;
            end
            MEM_WB: begin
               RegWrite = 1'b1;
               MemtoReg = 2'b01;
               retire   = 1'b1;
            end
            MEM_WR: begin
               mem_req  = 1'b1;
               IorD     = 1'b1;
               MemWrite = 1'b1;
               retire   = mem_ready;
            end
            EXEC_J: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
               retire   = 1'b1;
            end
            EXEC_JR: begin
               PCWrite  = 1'b1;
               PCSource = 2'b11;
               retire   = 1'b1;
            end
            EXEC_JAL: begin
               PCWrite  = 1'b1;
               PCSource = 2'b10;
               RegWrite = 1'b1;
               RegDst   = 2'b10;
               MemtoReg = 2'b10;
               retire   = 1'b1;
            end
            BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUSrcB     = 2'b00;
               ALUOp       = ALU_SUB;
               PCWriteCond = 1'b1;
               PCSource    = 2'b01;
               EQorNE      = (op_code == OP_BEQ);
               retire      = 1'b1;
            end
            ERROR: begin
               Error = 1'b1;
            end
            default: begin
               Error = 1'b1;
            end
         endcase
      end
   end

   // Next-state selection: handshake waits, opcode dispatch, timeout escape
   always_comb begin
      state_d = state_q;
      case (state_q)
         FETCH: begin
            if (mem_ready)        state_d = DECODE;
            else if (timeout_hit) state_d = ERROR;
         end
         DECODE: begin
            case (op_code)
               OP_RTYPE:                                   state_d = (funct == FN_JR) ? EXEC_JR : EXEC_R;
               OP_ANDI, OP_ORI, OP_XORI, OP_SLTI, OP_ADDI: state_d = EXEC_I;
               OP_LW, OP_SW:                               state_d = MEM_ADDR;
               OP_J:                                       state_d = EXEC_J;
               OP_JAL:                                     state_d = EXEC_JAL;
               OP_BEQ, OP_BNE:                             state_d = BRANCH;
               default:                                    state_d = ERROR;
            endcase
         end
         EXEC_R:   state_d = WB_R;
         EXEC_I:   state_d = WB_I;
         MEM_ADDR: begin
            if (op_code == OP_LW)      state_d = MEM_RD;
            else if (op_code == OP_SW) state_d = MEM_WR;
            else                       state_d = ERROR;
         end
         MEM_RD: begin
            if (mem_ready)        state_d = MEM_WB;
            else if (timeout_hit) state_d = ERROR;
         end
         MEM_WR: begin
            if (mem_ready)        state_d = FETCH;
            else if (timeout_hit) state_d = ERROR;
         end
         WB_R, WB_I, MEM_WB, EXEC_J, EXEC_JR, EXEC_JAL, BRANCH: state_d = FETCH;
         ERROR:    state_d = ERROR;
         default:  state_d = ERROR;
      endcase
   end

   // Wait counter restarts on every state change, so each access gets a fresh budget;
   // it saturates so a disabled timeout never wraps.
   always_comb begin
      to_d = to_q;
      if (state_d != state_q)
         to_d = '0;
      else if (stall && (to_q != {TO_W{1'b1}}))
         to_d = to_q + 1'b1;
   end

   // State and wait-counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         to_q    <= '0;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
      end
   end

`ifdef MIPS_CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt_q, instr_cnt_q, stall_cnt_q;

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
   assign stall_cnt = stall_cnt_q;

   // Performance counters: free-running modulo 2^32, frozen once the FSM is in ERROR
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_cnt_q <= '0;
         instr_cnt_q <= '0;
         stall_cnt_q <= '0;
      end else if (state_q != ERROR) begin
         cycle_cnt_q <= cycle_cnt_q + 32'd1;
         if (retire) instr_cnt_q <= instr_cnt_q + 32'd1;
         if (stall)  stall_cnt_q <= stall_cnt_q + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_mips_mc_control_hs.sv
// Bench for mips_mc_control_hs: table of per-cycle {inputs, expected outputs} vectors
// plus a hand-written store-timeout / sticky-error / reset-recovery sequence.
// Built with MEM_TIMEOUT=4 so the timeout boundary is reached quickly.
module tb_mips_mc_control_hs;

   localparam logic [4:0] S_FETCH = 5'd0,  S_DECODE = 5'd1,  S_EXEC_R = 5'd2,  S_WB_R = 5'd3;
   localparam logic [4:0] S_EXEC_I = 5'd4, S_WB_I = 5'd5,    S_MEM_ADDR = 5'd6, S_MEM_RD = 5'd7;
   localparam logic [4:0] S_MEM_WB = 5'd8, S_MEM_WR = 5'd9,  S_EXEC_J = 5'd10, S_EXEC_JR = 5'd11;
   localparam logic [4:0] S_EXEC_JAL = 5'd12, S_BRANCH = 5'd13, S_ERROR = 5'd14;

   localparam logic [5:0] OP_R = 6'b000000, OP_J = 6'b000010, OP_JAL = 6'b000011;
   localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ORI = 6'b001101;
   localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_BAD = 6'b111111;
   localparam logic [5:0] FN_ADD = 6'b100000, FN_JR = 6'b001000;

   localparam logic [2:0] A_OR = 3'b001, A_ADD = 3'b010, A_RT = 3'b100, A_SUB = 3'b110;

   // enable vector order: mem_req PCWrite PCWriteCond IorD MemWrite IRWrite ALUSrcA RegWrite EQorNE Error
   localparam logic [9:0] E_IDLE  = 10'b0000000010;
   localparam logic [9:0] E_FREQ  = 10'b1000000010;
   localparam logic [9:0] E_FDONE = 10'b1100010010;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op_code, funct;
   logic       mem_ready;
   logic       mem_req, PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, ALUSrcA, RegWrite, EQorNE, Error;
   logic [1:0] ALUSrcB, PCSource, RegDst, MemtoReg;
   logic [2:0] ALUOp;
   logic       retire;
   logic [4:0] state;
`ifdef MIPS_CTRL_PERF_CNT_EN
   logic [31:0] cycle_cnt, instr_cnt, stall_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mips_mc_control_hs #(.MEM_TIMEOUT(4), .TO_W(5), .STATE_W(5)) dut (
      .clk(clk), .rst(rst), .op_code(op_code), .funct(funct), .mem_ready(mem_ready),
      .mem_req(mem_req), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
      .MemWrite(MemWrite), .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
      .EQorNE(EQorNE), .Error(Error), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
      .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUOp(ALUOp), .retire(retire), .state(state)
`ifdef MIPS_CTRL_PERF_CNT_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt), .stall_cnt(stall_cnt)
`endif
   );

   logic [26:0] act;
   assign act = {state, mem_req, PCWrite, PCWriteCond, IorD, MemWrite, IRWrite, ALUSrcA,
                 RegWrite, EQorNE, Error, ALUSrcB, PCSource, RegDst, MemtoReg, ALUOp, retire};

   typedef struct {
      string      name;
      logic       r;
      logic [5:0] op;
      logic [5:0] fn;
      logic       rdy;
      logic [4:0] st;
      logic [9:0] en;
      logic [1:0] srcb, pcs, rdst, m2r;
      logic [2:0] aop;
      logic       ret;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input string n, input logic r, input logic [5:0] op, input logic [5:0] fn,
                      input logic rdy, input logic [4:0] st, input logic [9:0] en,
                      input logic [1:0] srcb, input logic [1:0] pcs, input logic [1:0] rdst,
                      input logic [1:0] m2r, input logic [2:0] aop, input logic ret);
      vec_t v;
      v.name = n; v.r = r; v.op = op; v.fn = fn; v.rdy = rdy; v.st = st; v.en = en;
      v.srcb = srcb; v.pcs = pcs; v.rdst = rdst; v.m2r = m2r; v.aop = aop; v.ret = ret;
      tbl.push_back(v);
   endtask

   // Drive inputs just after the falling edge; outputs settle well before the next rising edge
   task automatic drive(input logic r, input logic [5:0] op, input logic [5:0] fn, input logic rdy);
      @(negedge clk);
      rst = r; op_code = op; funct = fn; mem_ready = rdy;
      #1;
   endtask

   task automatic check(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", n, a, e);
      end
   endtask

   initial begin
      int wr_cycles;
      bit reached;

      rst = 1'b1; op_code = '0; funct = '0; mem_ready = 1'b0;
      repeat (2) @(posedge clk);

      //   name          r  op      fn      rdy state        enables        srcb   pcs    rdst   m2r    aluop  ret
      add("rst",        1, OP_R,   FN_ADD, 0, S_FETCH,    E_IDLE,        2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("add_fetch",  0, OP_R,   FN_ADD, 1, S_FETCH,    E_FDONE,       2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("add_dec",    0, OP_R,   FN_ADD, 1, S_DECODE,   E_IDLE,        2'b11, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("add_exec",   0, OP_R,   FN_ADD, 1, S_EXEC_R,   10'b0000001010, 2'b00, 2'b00, 2'b00, 2'b00, A_RT, 0);
      add("add_wb",     0, OP_R,   FN_ADD, 1, S_WB_R,     10'b0000000110, 2'b01, 2'b00, 2'b01, 2'b00, A_ADD, 1);
      add("lw_fwait",   0, OP_LW,  6'd0,   0, S_FETCH,    E_FREQ,        2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("lw_fetch",   0, OP_LW,  6'd0,   1, S_FETCH,    E_FDONE,       2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("lw_dec",     0, OP_LW,  6'd0,   1, S_DECODE,   E_IDLE,        2'b11, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("lw_addr",    0, OP_LW,  6'd0,   1, S_MEM_ADDR, 10'b0000001010, 2'b10, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("lw_wait1",   0, OP_LW,  6'd0,   0, S_MEM_RD,   10'b1001000010, 2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("lw_wait2",   0, OP_LW,  6'd0,   0, S_MEM_RD,   10'b1001000010, 2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("lw_wait3",   0, OP_LW,  6'd0,   0, S_MEM_RD,   10'b1001000010, 2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("lw_rd_lim",  0, OP_LW,  6'd0,   1, S_MEM_RD,   10'b1001000010, 2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("lw_wb",      0, OP_LW,  6'd0,   1, S_MEM_WB,   10'b0000000110, 2'b01, 2'b00, 2'b00, 2'b01, A_ADD, 1);
      add("sw_fetch",   0, OP_SW,  6'd0,   1, S_FETCH,    E_FDONE,       2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("sw_dec",     0, OP_SW,  6'd0,   1, S_DECODE,   E_IDLE,        2'b11, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("sw_addr",    0, OP_SW,  6'd0,   1, S_MEM_ADDR, 10'b0000001010, 2'b10, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("sw_wait1",   0, OP_SW,  6'd0,   0, S_MEM_WR,   10'b1001100010, 2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("sw_wait2",   0, OP_SW,  6'd0,   0, S_MEM_WR,   10'b1001100010, 2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("sw_wait3",   0, OP_SW,  6'd0,   0, S_MEM_WR,   10'b1001100010, 2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("sw_wr_lim",  0, OP_SW,  6'd0,   1, S_MEM_WR,   10'b1001100010, 2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 1);
      add("bne_fetch",  0, OP_BNE, 6'd0,   1, S_FETCH,    E_FDONE,       2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("bne_dec",    0, OP_BNE, 6'd0,   1, S_DECODE,   E_IDLE,        2'b11, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("bne_br",     0, OP_BNE, 6'd0,   1, S_BRANCH,   10'b0010001000, 2'b00, 2'b01, 2'b00, 2'b00, A_SUB, 1);
      add("beq_fetch",  0, OP_BEQ, 6'd0,   1, S_FETCH,    E_FDONE,       2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("beq_dec",    0, OP_BEQ, 6'd0,   1, S_DECODE,   E_IDLE,        2'b11, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("beq_br",     0, OP_BEQ, 6'd0,   1, S_BRANCH,   10'b0010001010, 2'b00, 2'b01, 2'b00, 2'b00, A_SUB, 1);
      add("ori_fetch",  0, OP_ORI, 6'd0,   1, S_FETCH,    E_FDONE,       2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("ori_dec",    0, OP_ORI, 6'd0,   1, S_DECODE,   E_IDLE,        2'b11, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("ori_exec",   0, OP_ORI, 6'd0,   1, S_EXEC_I,   10'b0000001010, 2'b10, 2'b00, 2'b00, 2'b00, A_OR, 0);
      add("ori_wb",     0, OP_ORI, 6'd0,   1, S_WB_I,     10'b0000000110, 2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 1);
      add("jr_fetch",   0, OP_R,   FN_JR,  1, S_FETCH,    E_FDONE,       2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("jr_dec",     0, OP_R,   FN_JR,  1, S_DECODE,   E_IDLE,        2'b11, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("jr_exec",    0, OP_R,   FN_JR,  1, S_EXEC_JR,  10'b0100000010, 2'b01, 2'b11, 2'b00, 2'b00, A_ADD, 1);
      add("j_fetch",    0, OP_J,   6'd0,   1, S_FETCH,    E_FDONE,       2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("j_dec",      0, OP_J,   6'd0,   1, S_DECODE,   E_IDLE,        2'b11, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("j_exec",     0, OP_J,   6'd0,   1, S_EXEC_J,   10'b0100000010, 2'b01, 2'b10, 2'b00, 2'b00, A_ADD, 1);
      add("jal_fetch",  0, OP_JAL, 6'd0,   1, S_FETCH,    E_FDONE,       2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("jal_dec",    0, OP_JAL, 6'd0,   1, S_DECODE,   E_IDLE,        2'b11, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("jal_exec",   0, OP_JAL, 6'd0,   1, S_EXEC_JAL, 10'b0100000110, 2'b01, 2'b10, 2'b10, 2'b10, A_ADD, 1);
      add("fw_wait1",   0, OP_BAD, 6'd0,   0, S_FETCH,    E_FREQ,        2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("fw_wait2",   0, OP_BAD, 6'd0,   0, S_FETCH,    E_FREQ,        2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("fw_wait3",   0, OP_BAD, 6'd0,   0, S_FETCH,    E_FREQ,        2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("fw_rst",     1, OP_BAD, 6'd0,   1, S_FETCH,    E_IDLE,        2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("fw_post1",   0, OP_BAD, 6'd0,   0, S_FETCH,    E_FREQ,        2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("fw_post2",   0, OP_BAD, 6'd0,   0, S_FETCH,    E_FREQ,        2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("fw_post3",   0, OP_BAD, 6'd0,   0, S_FETCH,    E_FREQ,        2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("bad_fetch",  0, OP_BAD, 6'd0,   1, S_FETCH,    E_FDONE,       2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("bad_dec",    0, OP_BAD, 6'd0,   1, S_DECODE,   E_IDLE,        2'b11, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("bad_err",    0, OP_BAD, 6'd0,   1, S_ERROR,    10'b0000000011, 2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("bad_rst",    1, OP_BAD, 6'd0,   1, S_ERROR,    E_IDLE,        2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);
      add("bad_rst2",   1, OP_R,   6'd0,   0, S_FETCH,    E_IDLE,        2'b01, 2'b00, 2'b00, 2'b00, A_ADD, 0);

      foreach (tbl[i]) begin
         drive(tbl[i].r, tbl[i].op, tbl[i].fn, tbl[i].rdy);
         check(tbl[i].name, 32'(act),
               32'({tbl[i].st, tbl[i].en, tbl[i].srcb, tbl[i].pcs, tbl[i].rdst,
                    tbl[i].m2r, tbl[i].aop, tbl[i].ret}));
      end

      // Store that never completes: MemWrite must be held for exactly MEM_TIMEOUT cycles
      drive(0, OP_SW, 6'd0, 1);
`ifdef MIPS_CTRL_PERF_CNT_EN
      check("perf_cycle_rst", cycle_cnt, 32'd0);
      check("perf_instr_rst", instr_cnt, 32'd0);
      check("perf_stall_rst", stall_cnt, 32'd0);
`endif
      check("to_fetch_state", 32'(state), 32'(S_FETCH));
      drive(0, OP_SW, 6'd0, 1);
      drive(0, OP_SW, 6'd0, 1);
      check("to_addr_state", 32'(state), 32'(S_MEM_ADDR));
      wr_cycles = 0;
      reached   = 1'b0;
      for (int i = 0; i < 20; i++) begin
         drive(0, OP_SW, 6'd0, 0);
         if (state == S_ERROR) begin
            reached = 1'b1;
            break;
         end
         if (MemWrite && mem_req && IorD) wr_cycles++;
      end
      check("to_reached_error", 32'(reached), 32'd1);
      check("to_memwrite_cycles", 32'(wr_cycles), 32'd4);
      check("to_error_flag", 32'({Error, mem_req, MemWrite, retire}), 32'b1000);

      // ERROR is sticky even if memory answers late
      drive(0, OP_SW, 6'd0, 1);
      check("err_sticky", 32'({state, Error}), 32'({S_ERROR, 1'b1}));
      drive(1, OP_R, 6'd0, 0);
      check("err_rst_gate", 32'(Error), 32'd0);
      drive(0, OP_R, FN_ADD, 0);
      check("err_recover", 32'({state, Error, mem_req}), 32'({S_FETCH, 1'b0, 1'b1}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
